// File: rtl/add_sub_sequencer.sv
// Sequential front-end driving a combinational WIDTH-bit adder/subtracter with an accumulator.
// Latency: LOAD/CLEAR 1 cycle, ADD/SUB 2 cycles from command accept to out_valid.
// Backpressure: one command in flight; in_ready drops until the result is taken via out_ready.
module add_sub_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_s,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;

   // The accumulator is what the consumer sees; it only moves on accept or in EXEC,
   // so it is naturally stable for the whole RESP stall.
   assign out_data = acc;

   // Command FSM: all outputs registered; adder inputs only move on ADD/SUB accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_s      <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_ovf    <= 1'b0;
         ovf_sticky <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  case (in_op)
                     OP_LOAD: begin
                        acc       <= in_data;
                        out_ovf   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= RESP;
                     end
                     OP_CLEAR: begin
                        acc        <= '0;
                        out_ovf    <= 1'b0;
                        ovf_sticky <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= RESP;
                     end
                     default: begin
                        // ADD or SUB: present operands to the adder, result lands next edge
                        add_a <= acc;
                        add_b <= in_data;
                        add_s <= (in_op == OP_SUB);
                        state <= EXEC;
                     end
                  endcase
               end
            end
            EXEC: begin
               acc        <= add_sum;
               out_ovf    <= add_v;
               ovf_sticky <= ovf_sticky | add_v;
               op_count   <= op_count + CNT_W'(1);
               out_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               // Retiring returns to IDLE only; a waiting command is taken on the next edge.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/add_sub_sequencer.md
Name: add_sub_sequencer

Overview:
- Sequential front-end for the combinational 4-bit binary adder/subtracter. It sits directly upstream of that adder.
- Accepts operand/opcode commands over a valid/ready handshake and holds an accumulator.
- Drives the adder's a, b and s inputs from registers, captures the adder's sum and v one cycle later, and returns the result and overflow over a second valid/ready handshake.

Parameters:
- WIDTH, 4, datapath width. Must match the adder width.
- CNT_W, 8, width of the completed-arithmetic-operation counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- in_data  input  WIDTH  operand. Ignored for CLEAR.
- add_a  output  WIDTH  to adder a; registered accumulator copy.
- add_b  output  WIDTH  to adder b; registered operand.
- add_s  output  1  to adder s; 1 = subtract.
- add_sum  input  WIDTH  from adder sum.
- add_v  input  1  from adder v (signed overflow).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  accumulator value after the command.
- out_ovf  output  1  overflow of this command. 0 for LOAD/CLEAR.
- ovf_sticky  output  1  OR of all overflows since reset or the last CLEAR.
- op_count  output  CNT_W  number of completed ADD/SUB commands.

Behaviour:
- Reset (async assert, sync release): state=IDLE; acc=0; add_a=0; add_b=0; add_s=0; out_valid=0; out_data=0; out_ovf=0; ovf_sticky=0; op_count=0. in_ready=1 once released.
- Reset asserted mid-operation aborts the operation immediately. No result is produced for it.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. A command is accepted when in_valid & in_ready at the clock edge.
    - LOAD: acc<=in_data; out_ovf<=0; go to RESP.
    - CLEAR: acc<=0; out_ovf<=0; ovf_sticky<=0; go to RESP.
    - ADD/SUB: add_a<=acc; add_b<=in_data; add_s<=(op==SUB); go to EXEC.
  - EXEC: exactly one cycle; in_ready=0. The adder is combinational, so add_sum/add_v are valid this cycle. On the edge:
    - acc<=add_sum; out_ovf<=add_v; ovf_sticky<=ovf_sticky|add_v.
    - op_count<=op_count+1, wrapping modulo 2^CNT_W.
    - Go to RESP.
  - RESP: out_valid=1; out_data=acc; in_ready=0. Stay until out_ready=1 at an edge, then go to IDLE.
- out_data and out_ovf are held stable for the whole RESP stall.
- add_a, add_b and add_s change only on ADD/SUB acceptance. They hold their values in all other states, so the adder inputs never glitch from this block.
- Latency, accept to out_valid:
  - LOAD/CLEAR: 1 cycle.
  - ADD/SUB: 2 cycles.
- Minimum command spacing: 3 cycles for ADD/SUB and 2 cycles for LOAD/CLEAR, with out_ready held high.
- Arithmetic is modulo 2^WIDTH, two's complement. The unsigned carry-out is not reported; only the adder's v is reported.
- in_valid while not in IDLE is not accepted. The upstream holds the command until it is accepted.
- out_ready while out_valid=0 has no effect.
- in_valid and out_ready high together in RESP: the result is retired in that cycle. The new command is accepted at the next edge in IDLE; there is no same-cycle pass-through.
- CLEAR does not reset op_count. Only rst_n does.

Test Plan:
- LOAD 5, then ADD 3 -> add_a=5, add_b=3, add_s=0 during EXEC. out_data=8, out_ovf=1 (4-bit signed 5+3 overflows), ovf_sticky=1, op_count=1. out_valid rises 2 cycles after accept.
- CLEAR, LOAD 2, SUB 3 -> add_s=1. out_data=4'hF (-1), out_ovf=0, ovf_sticky=0 after CLEAR, op_count incremented.
- Backpressure: ADD completes with out_ready=0 for 5 cycles -> out_valid, out_data and out_ovf stay constant. in_ready=0 throughout and in_valid pulses are ignored. Single retirement when out_ready=1.
- Reset mid-EXEC: assert rst_n=0 during EXEC -> all outputs reset asynchronously that cycle. No out_valid follows release. acc=0 and in_ready=1.
- LOAD 4'h8 then SUB 1 -> out_data=7, out_ovf=1. A following CLEAR -> out_data=0, out_ovf=0, ovf_sticky=0.
- 256 consecutive ADD 0 commands -> op_count wraps from 8'hFF to 8'h00. acc is unchanged.
